// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial frame transmitter (start, data, parity, stop)
module serial_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY    = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;

    logic             sout_d, frame_d, busy_d, done_d, ready_d;
    logic             div_end;
    logic             accept;

    assign div_end = (div_q == DIV_LAST);
    assign accept  = load_valid && (state_q == S_IDLE);

    // State, counters, shift register and latched parity
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // Next state: each bit lasts DIV cycles, counters restart on every state change
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    div_d   = '0;
                    bit_d   = '0;
                    shift_d = data_in;
                    // Parity is fixed at accept so later data_in changes cannot leak in
                    par_d   = (^data_in) ^ (PARITY == 2);
                end
            end
            S_START: begin
                if (div_end) begin
                    state_d = S_DATA;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_PARITY: begin
                if (div_end) begin
                    state_d = S_STOP;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (div_end) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_q
    always_comb begin
        sout_d  = 1'b1;
        frame_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_STOP) && (div_d == DIV_LAST);
        case (state_d)
            S_START:  sout_d = 1'b0;
            S_DATA:   sout_d = (MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0];
            S_PARITY: sout_d = par_d;
            default:  sout_d = 1'b1;
        endcase
    end

    // Output flops: sout drives downstream capture logic directly from a register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sout       <= 1'b1;
            frame      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            sout       <= sout_d;
            frame      <= frame_d;
            busy       <= busy_d;
            done       <= done_d;
            load_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx over several parameter sets
module tb_serial_frame_tx;

    logic       clock;
    logic       reset_n;
    logic [7:0] din [4];
    logic       din4;
    logic [4:0] valid;
    logic [4:0] ready_w, sout_w, frame_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;
    bit exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 0: W8 D4 MSB P0   1: even parity   2: odd parity   3: LSB first   4: W1 D1
    serial_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1), .PARITY(0)) u0 (
        .clock(clock), .reset_n(reset_n), .data_in(din[0]), .load_valid(valid[0]),
        .load_ready(ready_w[0]), .sout(sout_w[0]), .frame(frame_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    serial_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1), .PARITY(1)) u1 (
        .clock(clock), .reset_n(reset_n), .data_in(din[1]), .load_valid(valid[1]),
        .load_ready(ready_w[1]), .sout(sout_w[1]), .frame(frame_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    serial_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1), .PARITY(2)) u2 (
        .clock(clock), .reset_n(reset_n), .data_in(din[2]), .load_valid(valid[2]),
        .load_ready(ready_w[2]), .sout(sout_w[2]), .frame(frame_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    serial_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(0), .PARITY(0)) u3 (
        .clock(clock), .reset_n(reset_n), .data_in(din[3]), .load_valid(valid[3]),
        .load_ready(ready_w[3]), .sout(sout_w[3]), .frame(frame_w[3]), .busy(busy_w[3]), .done(done_w[3]));
    serial_frame_tx #(.WIDTH(1), .DIV(1), .MSB_FIRST(1), .PARITY(0)) u4 (
        .clock(clock), .reset_n(reset_n), .data_in(din4), .load_valid(valid[4]),
        .load_ready(ready_w[4]), .sout(sout_w[4]), .frame(frame_w[4]), .busy(busy_w[4]), .done(done_w[4]));

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Reference frame: start, data in the chosen order, optional parity, stop; each bit DIV cycles
    task automatic push_frame(input int w, input int dv, input bit msb, input int par, input logic [7:0] d);
        bit b;
        bit p;
        p = 1'b0;
        for (int i = 0; i < dv; i++) exp_q.push_back(1'b0);
        for (int j = 0; j < w; j++) begin
            b = msb ? d[w-1-j] : d[j];
            p = p ^ b;
            for (int i = 0; i < dv; i++) exp_q.push_back(b);
        end
        if (par != 0) begin
            if (par == 2) p = ~p;
            for (int i = 0; i < dv; i++) exp_q.push_back(p);
        end
        for (int i = 0; i < dv; i++) exp_q.push_back(1'b1);
    endtask

    task automatic set_data(input int k, input logic [7:0] d);
        if (k == 4) din4 = d[0];
        else        din[k] = d;
    endtask

    task automatic accept(input int k, input int w, input int dv, input bit msb, input int par,
                          input logic [7:0] d, input bit keep);
        @(negedge clock);
        set_data(k, d);
        valid[k] = 1'b1;
        push_frame(w, dv, msb, par, d);
        @(posedge clock);
        #1;
        if (!keep) valid[k] = 1'b0;
    endtask

    // Walk one frame of n cycles against the scoreboard, then the single idle cycle after it
    task automatic check_frame(input int k, input int n, input int glitch_at);
        bit e;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            if (glitch_at != 0 && c == glitch_at) begin
                valid[k] = 1'b1;
                set_data(k, 8'hFF);
            end
            if (glitch_at != 0 && c == glitch_at + 2) valid[k] = 1'b0;
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 1'b1, 1'b0);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            chk("sout", sout_w[k], e);
            chk("frame", frame_w[k], 1'b1);
            chk("busy", busy_w[k], 1'b1);
            chk("ready_low", ready_w[k], 1'b0);
            chk("done", done_w[k], (c == n));
        end
        @(negedge clock);
        chk("idle_ready", ready_w[k], 1'b1);
        chk("idle_sout", sout_w[k], 1'b1);
        chk("idle_busy", busy_w[k], 1'b0);
        chk("idle_done", done_w[k], 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = '0;
        din4    = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        #12;
        chk("rst_sout", sout_w[0], 1'b1);
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_frame", frame_w[0], 1'b0);
        chk("rst_done", done_w[0], 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("idle20_sout", sout_w[0], 1'b1);
            chk("idle20_ready", ready_w[0], 1'b1);
            chk("idle20_busy", busy_w[0], 1'b0);
            chk("idle20_frame", frame_w[0], 1'b0);
            chk("idle20_done", done_w[0], 1'b0);
        end

        // 0xA5 MSB first, no parity; a mid-frame load_valid pulse with new data is ignored
        accept(0, 8, 4, 1'b1, 0, 8'hA5, 1'b0);
        check_frame(0, 40, 10);

        // Even and odd parity, 44-cycle frames
        accept(1, 8, 4, 1'b1, 1, 8'hA5, 1'b0);
        check_frame(1, 44, 0);
        accept(2, 8, 4, 1'b1, 2, 8'hA5, 1'b0);
        check_frame(2, 44, 0);

        // LSB first
        accept(3, 8, 4, 1'b0, 0, 8'h01, 1'b0);
        check_frame(3, 40, 0);

        // Back-to-back frames with load_valid held high; data swapped mid-frame
        accept(0, 8, 4, 1'b1, 0, 8'h3C, 1'b1);
        set_data(0, 8'hC3);
        push_frame(8, 4, 1'b1, 0, 8'hC3);
        check_frame(0, 40, 0);
        @(posedge clock);
        #1;
        valid[0] = 1'b0;
        check_frame(0, 40, 0);

        // Asynchronous reset mid-frame
        accept(0, 8, 4, 1'b1, 0, 8'h5A, 1'b0);
        for (int c = 1; c < 15; c++) @(negedge clock);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_sout", sout_w[0], 1'b1);
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_frame", frame_w[0], 1'b0);
        chk("abort_done", done_w[0], 1'b0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            chk("post_abort_done", done_w[0], 1'b0);
            chk("post_abort_sout", sout_w[0], 1'b1);
        end
        accept(0, 8, 4, 1'b1, 0, 8'hA5, 1'b0);
        check_frame(0, 40, 0);

        // One-bit word, one cycle per bit
        accept(4, 1, 1, 1'b1, 0, 8'h01, 1'b0);
        check_frame(4, 3, 0);

        chk("scoreboard_empty", (exp_q.size() == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
